// File: rtl/top_level_dec.sv
// RSA decryption: message = cipher^d_key mod n, left-to-right square-and-always-multiply
// over a bit-serial interleaved modular multiplier. Latency is independent of the key bits.
module top_level_dec #(
   parameter int WIDTH = 128
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] cipher,
   input  logic [WIDTH-1:0] d_key,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] message,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_SQR,
      S_MUL,
      S_FIN
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] t_q, t_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [IW-1:0]    i_q, i_d;
   logic [IW-1:0]    j_q, j_d;
   logic [WIDTH-1:0] message_q, message_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] step_r;

   // One interleaved step: R = (2R + a_bit*b) mod n, with both reductions bounded by 2n.
   function automatic logic [WIDTH-1:0] modmul_step(input logic [WIDTH-1:0] r,
                                                    input logic             a_bit,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic [WIDTH-1:0] m);
      logic [WIDTH+1:0] t1;
      logic [WIDTH+1:0] m_ext;
      m_ext = {2'b00, m};
      t1    = {1'b0, r, 1'b0};
      if (t1 >= m_ext) t1 = t1 - m_ext;
      if (a_bit) t1 = t1 + {2'b00, b};
      if (t1 >= m_ext) t1 = t1 - m_ext;
      return t1[WIDTH-1:0];
   endfunction

   always_comb begin
      op_a   = (state_q == S_MUL) ? t_q : acc_q;
      op_b   = (state_q == S_MUL) ? c_q : acc_q;
      step_r = modmul_step(r_q, op_a[j_q], op_b, n_q);
   end

   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      d_d       = d_q;
      n_d       = n_q;
      acc_d     = acc_q;
      t_d       = t_q;
      r_d       = r_q;
      i_d       = i_q;
      j_d       = j_q;
      message_d = message_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      error_d   = error_q;

      unique case (state_q)
         S_IDLE: begin
            if (done_q) busy_d = 1'b0;
            // The done cycle is still the tail of the previous job, so start is not taken then.
            if (start && !done_q) begin
               c_d     = cipher;
               d_d     = d_key;
               n_d     = n;
               acc_d   = WIDTH'(1);
               i_d     = TOP;
               j_d     = TOP;
               r_d     = '0;
               error_d = 1'b0;
               busy_d  = 1'b1;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if ((n_q < WIDTH'(2)) || (c_q >= n_q)) begin
               message_d = '0;
               error_d   = 1'b1;
               state_d   = S_FIN;
            end else begin
               state_d = S_SQR;
            end
         end
         S_SQR: begin
            if (j_q == '0) begin
               t_d     = step_r;
               r_d     = '0;
               j_d     = TOP;
               state_d = S_MUL;
            end else begin
               r_d = step_r;
               j_d = j_q - 1'b1;
            end
         end
         S_MUL: begin
            if (j_q == '0) begin
               acc_d = d_q[i_q] ? step_r : t_q;
               r_d   = '0;
               j_d   = TOP;
               if (i_q == '0) begin
                  state_d = S_FIN;
               end else begin
                  i_d     = i_q - 1'b1;
                  state_d = S_SQR;
               end
            end else begin
               r_d = step_r;
               j_d = j_q - 1'b1;
            end
         end
         S_FIN: begin
            if (!error_q) message_d = acc_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         c_q       <= '0;
         d_q       <= '0;
         n_q       <= '0;
         acc_q     <= '0;
         t_q       <= '0;
         r_q       <= '0;
         i_q       <= '0;
         j_q       <= '0;
         message_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         c_q       <= c_d;
         d_q       <= d_d;
         n_q       <= n_d;
         acc_q     <= acc_d;
         t_q       <= t_d;
         r_q       <= r_d;
         i_q       <= i_d;
         j_q       <= j_d;
         message_q <= message_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign message = message_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;

endmodule

// File: tb/tb_top_level_dec.sv
// Directed bench for top_level_dec at WIDTH=16 against an arithmetic modular-exponent model.
module tb_top_level_dec;
   localparam int W   = 16;
   localparam int LAT = 2 * W * W + 2;

   logic         clock   = 1'b0;
   logic         reset_n = 1'b0;
   logic         start   = 1'b0;
   logic [W-1:0] cipher  = '0;
   logic [W-1:0] d_key   = '0;
   logic [W-1:0] n       = '0;
   logic [W-1:0] message;
   logic         busy;
   logic         done;
   logic         error;

   top_level_dec #(.WIDTH(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .cipher  (cipher),
      .d_key   (d_key),
      .n       (n),
      .message (message),
      .busy    (busy),
      .done    (done),
      .error   (error)
   );

   always #5 clock = ~clock;

   int     errors   = 0;
   int     checks   = 0;
   int     cyc      = 0;
   bit     pending  = 1'b0;
   int     acc_cyc  = 0;
   longint exp_msg  = 0;
   bit     exp_err  = 1'b0;
   int     exp_lat  = 0;
   longint last_msg = 0;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Right-to-left square-and-multiply on plain integers.
   function automatic void model(input longint c, input longint d, input longint nn,
                                 output longint m, output bit err);
      longint res, base, e;
      if (nn < 2 || c >= nn) begin
         m   = 0;
         err = 1'b1;
      end else begin
         res  = 1;
         base = c;
         e    = d;
         while (e > 0) begin
            if (e % 2 == 1) res = (res * base) % nn;
            base = (base * base) % nn;
            e    = e / 2;
         end
         m   = res;
         err = 1'b0;
      end
   endfunction

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (pending) begin
         chk("busy_while_running", busy, 1);
         if (done) begin
            chk("message", message, exp_msg);
            chk("error", error, exp_err);
            chk("latency", cyc - acc_cyc, exp_lat);
            $display("done: msg=%0d err=%0d lat=%0d (expected %0d/%0d/%0d)",
                     message, error, cyc - acc_cyc, exp_msg, exp_err, exp_lat);
            last_msg = exp_msg;
            pending  = 1'b0;
         end
      end else if (done) begin
         chk("unexpected_done", done, 0);
      end
   end

   task automatic run_op(input longint c, input longint d, input longint nn);
      longint m;
      bit     e;
      @(negedge clock);
      cipher = W'(c);
      d_key  = W'(d);
      n      = W'(nn);
      start  = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      model(c, d, nn, m, e);
      exp_msg = m;
      exp_err = e;
      exp_lat = e ? 2 : LAT;
      acc_cyc = cyc;
      pending = 1'b1;
      chk("error_cleared_on_start", error, 0);
      chk("message_held_on_start", message, last_msg);
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (pending && k < LAT + 50) begin
         @(posedge clock);
         k++;
      end
      if (pending) begin
         chk("done_timeout", 0, 1);
         pending = 1'b0;
      end
   endtask

   initial begin
      longint m, c;
      bit     e;
      int     k;

      model(741, 157, 2773, m, e);  chk("model_741", m, 2);
      model(2772, 157, 2773, m, e); chk("model_2772", m, 2772);
      model(5, 0, 2773, m, e);      chk("model_d0", m, 1);
      model(2, 17, 2773, m, e);     chk("model_enc2", m, 741);

      repeat (3) @(posedge clock);
      #1;
      chk("reset_message", message, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_error", error, 0);
      @(negedge clock);
      reset_n = 1'b1;

      run_op(741, 157, 2773);  wait_done();
      run_op(0, 157, 2773);    wait_done();
      run_op(1, 157, 2773);    wait_done();
      run_op(2772, 157, 2773); wait_done();
      run_op(5, 0, 2773);      wait_done();

      run_op(2773, 157, 2773); wait_done();
      run_op(5, 157, 1);       wait_done();
      run_op(741, 157, 2773);  wait_done();

      // Start with different operands while busy must be ignored.
      run_op(1234, 157, 2773);
      repeat (9) @(negedge clock);
      cipher = 99; d_key = 3; n = 1000; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done();

      // Start in the done cycle must be ignored; illegal operands would finish in 2 cycles if taken.
      run_op(741, 157, 2773);
      k = 0;
      while (pending && k < LAT + 50) begin
         @(negedge clock);
         #1;
         k++;
      end
      if (pending) begin
         chk("done_timeout", 0, 1);
         pending = 1'b0;
      end
      chk("done_seen", done, 1);
      cipher = 5; d_key = 3; n = 1; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      chk("start_in_done_busy", busy, 0);
      repeat (5) @(negedge clock);
      chk("start_in_done_message", message, last_msg);

      for (int it = 0; it < 50; it++) begin
         m = longint'($urandom_range(0, 2772));
         model(m, 17, 2773, c, e);
         run_op(c, 157, 2773);
         chk("roundtrip_model", exp_msg, m);
         wait_done();
      end

      run_op(741, 157, 2773);  wait_done();
      run_op(1234, 157, 2773);
      repeat (199) @(posedge clock);
      #1;
      pending = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("midreset_busy", busy, 0);
      chk("midreset_done", done, 0);
      chk("midreset_message", message, 0);
      chk("midreset_error", error, 0);
      last_msg = 0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (LAT + 10) @(negedge clock);
      run_op(741, 157, 2773);  wait_done();

      repeat (3) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
